// File: rtl/power_meter_ctrl_pkg.sv
// rtl/power_meter_ctrl_pkg.sv - shared game package: power meter states, ramp modes, bar geometry
//
// Purpose: types and constants shared by the power meter, its ramp unit and the bar renderer.
// Contents:
//   power_state_t               power meter FSM states
//   MODE_SATURATE/MODE_PINGPONG ramp behaviour selectors
//   POWER_MAX_DEFAULT           full-scale power (bar length in pixels)
//   POWER_BAR_*                 on-screen bar positions

package power_meter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHARGE   = 2'd1,
    ARMED    = 2'd2,
    COOLDOWN = 2'd3
  } power_state_t;

  localparam int MODE_SATURATE = 0;
  localparam int MODE_PINGPONG = 1;

  // Bar geometry; the maximum power equals the bar length so power is directly in pixels.
  localparam int POWER_MAX_DEFAULT = 200;
  localparam int POWER_BAR_P0_X    = 16;
  localparam int POWER_BAR_P1_X    = 424;
  localparam int POWER_BAR_Y       = 8;

endpackage

// File: rtl/power_meter_ctrl_ramp.sv
// rtl/power_meter_ctrl_ramp.sv - combinational one-step level/direction update unit
//
// Purpose: computes the next level and direction for one ramp step.
// Parameters: PW level width, POWER_MAX full scale, STEP increment, MODE saturate/pingpong.
// Ports:
//   i_power  in  PW  current level
//   i_dir    in  1   current direction (0 = up, 1 = down)
//   o_power  out PW  next level
//   o_dir    out 1   next direction

module power_meter_ctrl_ramp
  import power_meter_ctrl_pkg::*;
#(
  parameter int PW        = 8,
  parameter int POWER_MAX = POWER_MAX_DEFAULT,
  parameter int STEP      = 4,
  parameter int MODE      = MODE_SATURATE
) (
  input  logic [PW-1:0] i_power,
  input  logic          i_dir,
  output logic [PW-1:0] o_power,
  output logic          o_dir
);

  // One extra bit so the sum never wraps before it is compared with the maximum.
  localparam logic [PW:0]   L_STEP   = (PW+1)'(STEP);
  localparam logic [PW:0]   L_MAX    = (PW+1)'(POWER_MAX);
  localparam logic [PW-1:0] L_MAX_PW = PW'(POWER_MAX);

  logic [PW:0] w_p;
  logic [PW:0] w_sum;
  logic [PW:0] w_diff;

  assign w_p    = {1'b0, i_power};
  assign w_sum  = w_p + L_STEP;
  assign w_diff = w_p - L_STEP;

  always_comb begin
    o_power = i_power;
    o_dir   = i_dir;
    if (MODE == MODE_SATURATE) begin
      o_power = (w_sum >= L_MAX) ? L_MAX_PW : w_sum[PW-1:0];
      o_dir   = 1'b0;
    end else if (!i_dir) begin
      if (w_sum >= L_MAX) begin
        o_power = L_MAX_PW;
        o_dir   = 1'b1;
      end else begin
        o_power = w_sum[PW-1:0];
      end
    end else begin
      // Checked before subtracting, so the down ramp cannot go below zero.
      if (w_p <= L_STEP) begin
        o_power = '0;
        o_dir   = 1'b0;
      end else begin
        o_power = w_diff[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/power_meter_ctrl.sv
// rtl/power_meter_ctrl.sv - per-player throw-power meter with shot handshake
//
// Purpose: ramps the active player's power per frame while fire is held, latches it on
// release and offers the shot over valid/ready, then blocks the button for a cooldown.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   frame_tick                 one-cycle pulse per frame
//   enable                     turn in progress
//   active_player  [PLW]       player whose turn it is
//   fire_btn                   synchronised fire button
//   power_o        [NP*PW]     per-player levels, player k at [k*PW +: PW]
//   charging                   meter is charging
//   shot_valid/shot_ready      shot handshake
//   shot_power     [PW]        latched power of the offered shot
//   shot_player    [PLW]       player that fired

module power_meter_ctrl
  import power_meter_ctrl_pkg::*;
#(
  parameter  int NUM_PLAYERS     = 2,
  parameter  int POWER_MAX       = POWER_MAX_DEFAULT,
  parameter  int STEP            = 4,
  parameter  int MODE            = MODE_SATURATE,
  parameter  int COOLDOWN_FRAMES = 30,
  localparam int PLW             = $clog2(NUM_PLAYERS),
  localparam int PW              = $clog2(POWER_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic                      enable,
  input  logic [PLW-1:0]            active_player,
  input  logic                      fire_btn,
  output logic [NUM_PLAYERS*PW-1:0] power_o,
  output logic                      charging,
  output logic                      shot_valid,
  output logic [PW-1:0]             shot_power,
  output logic [PLW-1:0]            shot_player,
  input  logic                      shot_ready
);

  localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  power_state_t                      r_state;
  power_state_t                      w_state_nxt;
  logic [NUM_PLAYERS-1:0][PW-1:0]    r_power;
  logic [PLW-1:0]                    r_cur;
  logic                              r_dir;
  logic [CW-1:0]                     r_cool;
  logic                              r_charging;
  logic                              r_shot_valid;
  logic [PW-1:0]                     r_shot_power;
  logic [PLW-1:0]                    r_shot_player;
  logic [PW-1:0]                     w_pow_nxt;
  logic                              w_dir_nxt;

  power_meter_ctrl_ramp #(
    .PW        (PW),
    .POWER_MAX (POWER_MAX),
    .STEP      (STEP),
    .MODE      (MODE)
  ) u_ramp (
    .i_power (r_power[r_cur]),
    .i_dir   (r_dir),
    .o_power (w_pow_nxt),
    .o_dir   (w_dir_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (enable && fire_btn) w_state_nxt = CHARGE;
      // Losing the turn beats a release: an aborted charge never produces a shot.
      CHARGE:   if (!enable) w_state_nxt = IDLE;
                else if (!fire_btn) w_state_nxt = ARMED;
      ARMED:    if (shot_ready) w_state_nxt = COOLDOWN;
      COOLDOWN: if (r_cool == '0) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_power       <= '0;
      r_cur         <= '0;
      r_dir         <= 1'b0;
      r_cool        <= '0;
      r_charging    <= 1'b0;
      r_shot_valid  <= 1'b0;
      r_shot_power  <= '0;
      r_shot_player <= '0;
    end else begin
      r_charging <= (w_state_nxt == CHARGE);
      case (r_state)
        IDLE: begin
          if (enable && fire_btn) begin
            r_cur                  <= active_player;
            r_power[active_player] <= '0;
            r_dir                  <= 1'b0;
          end
        end
        CHARGE: begin
          // Release takes priority over a coincident frame_tick, so the shot
          // carries the level the player saw when letting go.
          if (!enable) begin
            r_power[r_cur] <= '0;
          end else if (!fire_btn) begin
            r_shot_valid  <= 1'b1;
            r_shot_power  <= r_power[r_cur];
            r_shot_player <= r_cur;
          end else if (frame_tick) begin
            r_power[r_cur] <= w_pow_nxt;
            r_dir          <= w_dir_nxt;
          end
        end
        ARMED: begin
          if (shot_ready) begin
            r_shot_valid <= 1'b0;
            r_cool       <= CW'(COOLDOWN_FRAMES);
          end
        end
        COOLDOWN: begin
          if (frame_tick && (r_cool != '0)) r_cool <= r_cool - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign power_o     = r_power;
  assign charging    = r_charging;
  assign shot_valid  = r_shot_valid;
  assign shot_power  = r_shot_power;
  assign shot_player = r_shot_player;

endmodule

// File: tb/tb_power_meter_ctrl.sv
// tb/tb_power_meter_ctrl.sv - self-checking bench for power_meter_ctrl (saturate and pingpong)

module tb_power_meter_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b0;
  logic        active_player = 1'b0;
  logic        fire_btn = 1'b0;
  logic        shot_ready = 1'b0;

  logic [15:0] s_power_o, p_power_o;
  logic        s_charging, p_charging;
  logic        s_shot_valid, p_shot_valid;
  logic [7:0]  s_shot_power, p_shot_power;
  logic        s_shot_player, p_shot_player;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int pwr;
    int pl;
  } shot_t;

  typedef struct {
    int ticks;
    int exp_sat;
    int exp_pp;
  } ramp_vec_t;

  shot_t     q_sat[$];
  shot_t     q_pp[$];
  ramp_vec_t tbl[11];

  always #5 clk = ~clk;

  power_meter_ctrl #(
    .NUM_PLAYERS(2), .POWER_MAX(200), .STEP(4), .MODE(0), .COOLDOWN_FRAMES(30)
  ) u_sat (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .active_player(active_player), .fire_btn(fire_btn), .power_o(s_power_o),
    .charging(s_charging), .shot_valid(s_shot_valid), .shot_power(s_shot_power),
    .shot_player(s_shot_player), .shot_ready(shot_ready)
  );

  power_meter_ctrl #(
    .NUM_PLAYERS(2), .POWER_MAX(200), .STEP(8), .MODE(1), .COOLDOWN_FRAMES(30)
  ) u_pp (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .active_player(active_player), .fire_btn(fire_btn), .power_o(p_power_o),
    .charging(p_charging), .shot_valid(p_shot_valid), .shot_power(p_shot_power),
    .shot_player(p_shot_player), .shot_ready(shot_ready)
  );

  function automatic int lvl(input logic [15:0] v, input int k);
    return int'(v[k*8 +: 8]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are checked 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic accept();
    shot_ready = 1'b1;
    step();
    shot_ready = 1'b0;
    check("sat_valid_drop", int'(s_shot_valid), 0);
    check("pp_valid_drop", int'(p_shot_valid), 0);
  endtask

  // Handshake observed on the falling edge; it completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && shot_ready) begin
      if (s_shot_valid) begin
        if (q_sat.size() == 0) begin
          check("sat_unexpected_shot", 1, 0);
        end else begin
          shot_t e;
          e = q_sat.pop_front();
          check("sat_sb_power", int'(s_shot_power), e.pwr);
          check("sat_sb_player", int'(s_shot_player), e.pl);
        end
      end
      if (p_shot_valid) begin
        if (q_pp.size() == 0) begin
          check("pp_unexpected_shot", 1, 0);
        end else begin
          shot_t e;
          e = q_pp.pop_front();
          check("pp_sb_power", int'(p_shot_power), e.pwr);
          check("pp_sb_player", int'(p_shot_player), e.pl);
        end
      end
    end
  end

  initial begin
    int done;
    tbl[0]  = '{1, 4, 8};
    tbl[1]  = '{10, 40, 80};
    tbl[2]  = '{24, 96, 192};
    tbl[3]  = '{25, 100, 200};
    tbl[4]  = '{26, 104, 192};
    tbl[5]  = '{30, 120, 160};
    tbl[6]  = '{49, 196, 8};
    tbl[7]  = '{50, 200, 0};
    tbl[8]  = '{51, 200, 8};
    tbl[9]  = '{55, 200, 40};
    tbl[10] = '{60, 200, 80};

    // Reset state
    step();
    check("rst_sat_power", int'(s_power_o), 0);
    check("rst_pp_power", int'(p_power_o), 0);
    check("rst_charging", int'(s_charging), 0);
    check("rst_valid", int'(s_shot_valid), 0);
    rst = 1'b0;
    step();

    // Ramp table, player 0, continuous hold
    enable = 1'b1;
    fire_btn = 1'b1;
    active_player = 1'b0;
    step();
    check("sat_charging", int'(s_charging), 1);
    check("pp_charging", int'(p_charging), 1);
    done = 0;
    for (int i = 0; i < 11; i++) begin
      while (done < tbl[i].ticks) begin
        tick();
        done++;
      end
      check($sformatf("sat_ramp_%0d", tbl[i].ticks), lvl(s_power_o, 0), tbl[i].exp_sat);
      check($sformatf("pp_ramp_%0d", tbl[i].ticks), lvl(p_power_o, 0), tbl[i].exp_pp);
    end

    // Release, stalled consumer
    fire_btn = 1'b0;
    q_sat.push_back('{200, 0});
    q_pp.push_back('{80, 0});
    step();
    for (int i = 0; i < 10; i++) begin
      check("sat_stall_valid", int'(s_shot_valid), 1);
      check("sat_stall_power", int'(s_shot_power), 200);
      check("sat_stall_player", int'(s_shot_player), 0);
      check("pp_stall_power", int'(p_shot_power), 80);
      step();
    end
    accept();

    // Cooldown: held button ignored for 30 frames
    fire_btn = 1'b1;
    ticks(29);
    step();
    step();
    step();
    check("cool_charging_29", int'(s_charging), 0);
    check("cool_sat_keep", lvl(s_power_o, 0), 200);
    check("cool_pp_keep", lvl(p_power_o, 0), 80);
    tick();
    step();
    check("cool_recharge_30", int'(s_charging), 1);
    check("recharge_zero", lvl(s_power_o, 0), 0);

    // Release coincident with frame_tick
    ticks(24);
    check("sat_pre_release", lvl(s_power_o, 0), 96);
    fire_btn = 1'b0;
    frame_tick = 1'b1;
    q_sat.push_back('{96, 0});
    q_pp.push_back('{192, 0});
    step();
    frame_tick = 1'b0;
    check("sat_coinc_power", int'(s_shot_power), 96);
    check("pp_coinc_power", int'(p_shot_power), 192);
    accept();
    ticks(30);
    step();
    step();
    check("idle_after_cool", int'(s_charging), 0);

    // Player 1, pingpong down-ramp, active_player change ignored
    active_player = 1'b1;
    fire_btn = 1'b1;
    step();
    ticks(10);
    active_player = 1'b0;
    ticks(20);
    check("pp_p1_power", lvl(p_power_o, 1), 160);
    check("sat_p1_power", lvl(s_power_o, 1), 120);
    fire_btn = 1'b0;
    q_sat.push_back('{120, 1});
    q_pp.push_back('{160, 1});
    step();
    check("pp_p1_player", int'(p_shot_player), 1);
    check("pp_p0_unchanged", lvl(p_power_o, 0), 192);
    check("sat_p0_unchanged", lvl(s_power_o, 0), 96);
    accept();
    ticks(30);
    step();
    step();

    // enable drops mid-charge together with release
    active_player = 1'b1;
    fire_btn = 1'b1;
    step();
    ticks(30);
    check("sat_abort_pre", lvl(s_power_o, 1), 120);
    enable = 1'b0;
    fire_btn = 1'b0;
    step();
    check("abort_charging", int'(s_charging), 0);
    check("abort_sat_zero", lvl(s_power_o, 1), 0);
    check("abort_pp_zero", lvl(p_power_o, 1), 0);
    check("abort_p0_keep", lvl(s_power_o, 0), 96);
    for (int i = 0; i < 5; i++) begin
      check("abort_no_valid", int'(s_shot_valid | p_shot_valid), 0);
      step();
    end
    enable = 1'b1;

    // Asynchronous reset while armed
    active_player = 1'b0;
    fire_btn = 1'b1;
    step();
    ticks(5);
    fire_btn = 1'b0;
    step();
    check("armed_valid", int'(s_shot_valid), 1);
    check("armed_power", int'(s_shot_power), 20);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(s_shot_valid | p_shot_valid), 0);
    check("async_rst_power_o", int'(s_power_o | p_power_o), 0);
    check("async_rst_shot_power", int'(s_shot_power | p_shot_power), 0);
    check("async_rst_charging", int'(s_charging | p_charging), 0);
    step();
    rst = 1'b0;
    step();
    step();
    check("post_rst_idle", int'(s_charging), 0);
    check("post_rst_valid", int'(s_shot_valid), 0);

    check("sat_queue_empty", q_sat.size(), 0);
    check("pp_queue_empty", q_pp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
